// File: rtl/sram_rd_arbiter_if.sv
// Purpose: bundles the loader-facing request/data signals and the SRAM port of
//          the read arbiter. Port summary: per-requester rden/addr/lock in,
//          one-hot grant and read-valid out, broadcast read data, SRAM addr/rden/data.
interface sram_rd_arbiter_if #(
  parameter int ADR_W  = 16,
  parameter int SRAM_W = 32,
  parameter int N_REQ  = 3
);
  logic [N_REQ-1:0]       i_req_rden;
  logic [N_REQ*ADR_W-1:0] i_req_addr;
  logic [N_REQ-1:0]       i_req_lock;
  logic [N_REQ-1:0]       o_gnt;
  logic [N_REQ-1:0]       o_rd_valid;
  logic [SRAM_W-1:0]      o_rd_data;
  logic [ADR_W-1:0]       o_sram_addr;
  logic                   o_sram_rden;
  logic [SRAM_W-1:0]      i_sram_data;
  logic                   o_busy;

  // Arbiter side.
  modport slave (
    input  i_req_rden, i_req_addr, i_req_lock, i_sram_data,
    output o_gnt, o_rd_valid, o_rd_data, o_sram_addr, o_sram_rden, o_busy
  );

  // Loader / SRAM side.
  modport master (
    output i_req_rden, i_req_addr, i_req_lock, i_sram_data,
    input  o_gnt, o_rd_valid, o_rd_data, o_sram_addr, o_sram_rden, o_busy
  );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Purpose: round-robin arbiter sharing one SRAM read port among N_REQ loaders,
//          bounded bursts, lock to hold a full weight tile.
// Latency: request->grant 1 cycle, beat->rd_valid/data 1 cycle; rotation at a
//          burst boundary has no bubble, an owner dropping rden costs one bubble.
// Backpressure: a requester holds rden until granted; ungranted requesters see nothing.
// Ports: i_clk, i_rstn (sync, active-low), bus (slave modport of sram_rd_arbiter_if).
module sram_rd_arbiter #(
  parameter int ADR_W     = 16,
  parameter int SRAM_W    = 32,
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  sram_rd_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rd_valid;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;

  // First set bit of req searching cyclically from start, as a one-hot vector.
  function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] req, input int start);
    logic [N_REQ-1:0] oh;
    logic             found;
    int               idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (start + k) % N_REQ;
      if (!found && req[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  logic [N_REQ-1:0] beat_vec;
  logic             beat;
  logic [N_REQ-1:0] others_vec;
  logic             others;
  logic             owner_lock;
  logic [N_REQ-1:0] idle_pick;
  logic [N_REQ-1:0] own_pick;
  logic [CNT_W-1:0] cnt_sat;
  logic             burst_end;
  logic [ADR_W-1:0] sram_addr;

  assign beat_vec   = gnt & bus.i_req_rden;
  assign beat       = |beat_vec;
  // Pending requesters other than the current owner.
  assign others_vec = bus.i_req_rden & ~gnt;
  assign others     = |others_vec;
  assign owner_lock = |(gnt & bus.i_req_lock);
  assign idle_pick  = pick(bus.i_req_rden, int'(rr_ptr));
  // Owner is masked out, so a search from owner+1 finds the next one after it.
  assign own_pick   = pick(others_vec, int'(owner) + 1);
  // Beat count including this cycle's beat, saturating while locked.
  assign cnt_sat    = (cnt == CNT_W'(MAX_BURST)) ? cnt : cnt + CNT_W'(1);
  assign burst_end  = (cnt_sat == CNT_W'(MAX_BURST)) && !owner_lock;

  always_comb begin
    sram_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sram_addr = bus.i_req_addr[i*ADR_W +: ADR_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= S_IDLE;
      gnt      <= '0;
      rd_valid <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
    end else begin
      rd_valid <= beat_vec;
      case (state)
        S_IDLE: begin
          if (|bus.i_req_rden) begin
            gnt    <= idle_pick;
            owner  <= oh2idx(idle_pick);
            rr_ptr <= idx_inc(oh2idx(idle_pick));
            cnt    <= '0;
            state  <= S_OWN;
          end
        end
        S_OWN: begin
          if (!beat) begin
            // Owner released the port: this cycle is a bubble.
            cnt <= '0;
            if (others) begin
              gnt   <= own_pick;
              owner <= oh2idx(own_pick);
            end else begin
              gnt   <= '0;
              state <= S_IDLE;
            end
          end else if (burst_end && others) begin
            gnt   <= own_pick;
            owner <= oh2idx(own_pick);
            cnt   <= '0;
          end else if (burst_end) begin
            cnt <= '0;
          end else begin
            cnt <= cnt_sat;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rd_valid  = rd_valid;
  assign bus.o_rd_data   = bus.i_sram_data;
  assign bus.o_sram_addr = sram_addr;
  assign bus.o_sram_rden = beat;
  assign bus.o_busy      = |gnt;

endmodule

// File: doc/sram_rd_arbiter.md
Name: sram_rd_arbiter

Overview:
- Shares the single weight/activation SRAM read port between N_REQ loaders: weights loader, ifmap loader and bias loader.
- Grants are round-robin with a bounded burst length.
- A lock input lets a loader finish a full per-channel weight tile without being preempted.
- Sits between the loaders and the SRAM macro. Read data is broadcast and qualified by a per-requester valid.

Parameters:
- ADR_W, 16, SRAM address width.
- SRAM_W, 32, SRAM data width.
- N_REQ, 3, number of requesters (index 0 = weights loader).
- MAX_BURST, 8, maximum consecutive beats before forced rotation when another requester is pending.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; synchronous, active-low.
- i_req_rden  in  N_REQ  per-requester read request; must be held until granted.
- i_req_addr  in  N_REQ*ADR_W  per-requester address; slice i belongs to requester i.
- i_req_lock  in  N_REQ  while high and owning, burst rotation is suppressed.
- o_gnt  out  N_REQ  registered one-hot grant.
- o_rd_valid  out  N_REQ  registered; o_rd_data is valid for requester i this cycle.
- o_rd_data  out  SRAM_W  equals i_sram_data, broadcast to all requesters.
- o_sram_addr  out  ADR_W  address to SRAM.
- o_sram_rden  out  1  read enable to SRAM.
- i_sram_data  in  SRAM_W  SRAM read data, 1-cycle latency.
- o_busy  out  1  equals |o_gnt.

Behaviour:
- Reset values (i_rstn low at a clock edge): o_gnt=0, o_rd_valid=0, beat counter=0, rr_ptr=0. Reset mid-burst discards the in-flight read: o_rd_valid stays 0 the cycle after reset.
- Combinational outputs:
  - o_sram_rden = |(o_gnt & i_req_rden).
  - o_sram_addr = address slice of the granted requester; 0 when o_gnt==0.
- Beat: a cycle in which o_gnt[i] and i_req_rden[i] are both high.
- o_rd_valid[i] at t+1 = beat issued by requester i at t. Data return latency is exactly 1 cycle after the beat.
- State IDLE (o_gnt==0): if any i_req_rden is high, grant at the next edge to the first requester at or after rr_ptr (cyclic search). Set rr_ptr = winner+1 mod N_REQ and clear the beat counter.
- State OWN(i), next-edge decision:
  - i_req_rden[i] low: grant the next pending requester searching cyclically from i+1. If none is pending, go to IDLE. This cycle is a bubble with no SRAM read.
  - Counter reaches MAX_BURST on this beat, i_req_lock[i] low, and another requester pending: rotate to the next pending requester after i. Requester i keeps rden high and waits its turn.
  - Counter reaches MAX_BURST, no other requester pending: stay in OWN(i) and clear the counter.
  - i_req_lock[i] high: no rotation. The counter saturates at MAX_BURST.
- Counter width: $clog2(MAX_BURST+1). It increments only on beats and clears on every grant change.
- Timing: a request at t from IDLE gives grant at t+1, first beat at t+1, and data valid at t+2. Grant change at a burst boundary has no bubble: the last old beat is at t and the first new beat is at t+1.
- Simultaneous requests in IDLE are resolved purely by rr_ptr.
- A request that drops before being granted is ignored.
- i_req_addr changes are accepted every beat, so an address may change each cycle.
- Requesters whose rden is high without a grant see no side effects.

Test Plan:
- Single requester, weights (idx 0): rden high for 5 cycles at addresses 0x10..0x14 → gnt[0] one cycle after rden, o_sram_addr follows 0x10..0x14, o_rd_valid[0] high for 5 cycles starting 2 cycles after rden, data matches the SRAM model.
- Requesters 0 and 1 both request continuously, lock=0, MAX_BURST=8 → grants alternate in blocks of 8 beats, no bubble at handover, 16 valids in 16 cycles after the first grant.
- Requester 0 with lock=1 fetching 36 words while 1 and 2 request → gnt[0] held for all 36 beats. Then 1 gets 8 beats, 2 gets 8 beats, then back to 1.
- Owner 1 drops rden at cycle t while 2 is pending → at t, o_sram_rden=0. At t+1, gnt=3'b100 and the first beat of requester 2 is issued.
- Reset asserted mid-burst after 3 beats → next cycle o_gnt=0, o_rd_valid=0, o_sram_rden=0. After release, the first grant goes to requester 0 (rr_ptr=0).
- All three request simultaneously from IDLE, starting with rr_ptr=2 → grant order is 2, 0, 1.
